// File: rtl/qdr_traffic_gen.sv
// QDRII+ user-interface traffic generator and checker.
// Writes a pattern over an address window, reads it back, and compares each
// returned burst against the pattern regenerated from the expected address.
module qdr_traffic_gen #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 18,
  parameter int BW_WIDTH   = 4,
  parameter int BURST_LEN  = 4,
  parameter int ADDR_START = 0,
  parameter int ADDR_END   = 1023,
  parameter int TIMEOUT    = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               init_calib_complete,
  input  logic                               start,
  input  logic                               loop_en,
  input  logic [1:0]                         pattern_mode,
  output logic                               app_wr_cmd,
  output logic [ADDR_WIDTH-1:0]              app_wr_addr,
  output logic [DATA_WIDTH*BURST_LEN-1:0]    app_wr_data,
  output logic [BW_WIDTH*BURST_LEN-1:0]      app_wr_bw_n,
  output logic                               app_rd_cmd,
  output logic [ADDR_WIDTH-1:0]              app_rd_addr,
  input  logic                               app_rd_valid,
  input  logic [DATA_WIDTH*BURST_LEN-1:0]    app_rd_data,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic                               timeout_err,
  output logic [15:0]                        err_count,
  output logic [ADDR_WIDTH-1:0]              first_err_addr,
  output logic [15:0]                        pass_count
);

  localparam int UW = DATA_WIDTH * BURST_LEN;
  localparam logic [ADDR_WIDTH-1:0] A_START = ADDR_WIDTH'(ADDR_START);
  localparam logic [ADDR_WIDTH-1:0] A_END   = ADDR_WIDTH'(ADDR_END);
  localparam logic [ADDR_WIDTH:0]   N_RD    = (ADDR_WIDTH+1)'(ADDR_END - ADDR_START + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  function automatic logic [DATA_WIDTH-1:0] beat_pat(input logic [1:0] mode, input logic inv,
                                                     input logic [ADDR_WIDTH-1:0] a, input int b);
    logic [31:0] sum, pos;
    logic [DATA_WIDTH-1:0] w;
    sum = 32'(a) + 32'(b);
    pos = (32'(a) * 32'(BURST_LEN) + 32'(b)) % 32'(DATA_WIDTH);
    case (mode)
      2'd0:    w = DATA_WIDTH'(sum);
      2'd1:    w = DATA_WIDTH'(1) << pos;
      2'd2:    w = ~DATA_WIDTH'(sum);
      default: w = {DATA_WIDTH{~sum[0]}};
    endcase
    return inv ? ~w : w;
  endfunction

  function automatic logic [UW-1:0] burst_pat(input logic [1:0] mode, input logic inv,
                                              input logic [ADDR_WIDTH-1:0] a);
    logic [UW-1:0] r;
    r = '0;
    for (int b = 0; b < BURST_LEN; b++) r[b*DATA_WIDTH +: DATA_WIDTH] = beat_pat(mode, inv, a, b);
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic                  inv_q, inv_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic [TW-1:0]         idle_cnt;
  logic                  go, restart, complete, tmo, chk, mismatch;

  // Returned reads are only checked while a test is active, so stragglers
  // arriving after reset or calibration loss leave the status untouched.
  assign chk      = app_rd_valid && (state_q != S_IDLE);
  assign mismatch = chk && (app_rd_data != burst_pat(mode_q, inv_q, exp_addr));
  assign app_wr_bw_n = '0;

  // Next-state logic plus the write-side address/pattern selection.
  always_comb begin
    state_d  = state_q;
    go       = 1'b0;
    complete = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      S_IDLE:  if (start && init_calib_complete) begin state_d = S_WRITE; go = 1'b1; end
      S_WRITE: if (app_wr_addr == A_END) state_d = S_READ;
      S_READ:  if (app_rd_addr == A_END) state_d = S_DRAIN;
      S_DRAIN: begin
        if (rd_cnt == N_RD) begin
          complete = 1'b1;
          state_d  = loop_en ? S_WRITE : S_IDLE;
        end else if (!app_rd_valid && idle_cnt == T_LAST) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !init_calib_complete) begin
      state_d  = S_IDLE;
      complete = 1'b0;
      tmo      = 1'b0;
    end
    restart   = complete && (state_d == S_WRITE);
    mode_d    = go ? pattern_mode : mode_q;
    inv_d     = go ? 1'b0 : (restart ? ~inv_q : inv_q);
    wr_addr_d = app_wr_addr;
    if (go || restart) wr_addr_d = A_START;
    else if (state_q == S_WRITE && state_d == S_WRITE) wr_addr_d = app_wr_addr + ADDR_WIDTH'(1);
  end

  // State, command outputs, read tracking and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mode_q         <= 2'd0;
      inv_q          <= 1'b0;
      app_wr_cmd     <= 1'b0;
      app_wr_addr    <= A_START;
      app_wr_data    <= '0;
      app_rd_cmd     <= 1'b0;
      app_rd_addr    <= A_START;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      timeout_err    <= 1'b0;
      err_count      <= 16'd0;
      first_err_addr <= A_START;
      pass_count     <= 16'd0;
      exp_addr       <= A_START;
      rd_cnt         <= '0;
      idle_cnt       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      inv_q       <= inv_d;
      busy        <= (state_d != S_IDLE);
      done        <= (complete && state_d == S_IDLE) || tmo;
      app_wr_cmd  <= (state_d == S_WRITE);
      app_rd_cmd  <= (state_d == S_READ);
      app_wr_addr <= wr_addr_d;
      if (state_d == S_WRITE) app_wr_data <= burst_pat(mode_d, inv_d, wr_addr_d);
      if (state_q == S_WRITE && state_d == S_READ) app_rd_addr <= A_START;
      else if (state_q == S_READ && state_d == S_READ) app_rd_addr <= app_rd_addr + ADDR_WIDTH'(1);

      // idle timer only runs while waiting in DRAIN; any return restarts it
      if (state_q == S_DRAIN && state_d == S_DRAIN)
        idle_cnt <= app_rd_valid ? '0 : idle_cnt + TW'(1);
      else
        idle_cnt <= '0;

      if (go || restart) begin
        exp_addr <= A_START;
        rd_cnt   <= '0;
      end else if (chk && rd_cnt != N_RD) begin
        exp_addr <= exp_addr + ADDR_WIDTH'(1);
        rd_cnt   <= rd_cnt + (ADDR_WIDTH+1)'(1);
      end

      if (go) begin
        error          <= 1'b0;
        timeout_err    <= 1'b0;
        err_count      <= 16'd0;
        first_err_addr <= A_START;
        pass_count     <= 16'd0;
      end else begin
        if (mismatch) begin
          error <= 1'b1;
          if (err_count == 16'd0) first_err_addr <= exp_addr;
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
        if (tmo) begin
          error       <= 1'b1;
          timeout_err <= 1'b1;
        end
        if (complete) pass_count <= pass_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_qdr_traffic_gen.sv
// Directed + randomized bench for qdr_traffic_gen over a 16-word window,
// backed by an in-order SRAM model with configurable latency and faults.
module tb_qdr_traffic_gen;
  localparam int DW = 36, AW = 18, BWW = 4, BL = 4, AS = 0, AE = 15, TO = 64;
  localparam int N = AE - AS + 1, UW = DW * BL;

  logic clk = 1'b0, rst_n = 1'b0, calib = 1'b0, start = 1'b0, loop_en = 1'b0;
  logic [1:0] pattern_mode = 2'd0;
  logic app_wr_cmd, app_rd_cmd, busy, done, error, timeout_err;
  logic [AW-1:0] app_wr_addr, app_rd_addr, first_err_addr;
  logic [UW-1:0] app_wr_data, app_rd_data;
  logic [BWW*BL-1:0] app_wr_bw_n;
  logic app_rd_valid;
  logic [15:0] err_count, pass_count;

  qdr_traffic_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BW_WIDTH(BWW), .BURST_LEN(BL),
                    .ADDR_START(AS), .ADDR_END(AE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(calib), .start(start), .loop_en(loop_en),
    .pattern_mode(pattern_mode), .app_wr_cmd(app_wr_cmd), .app_wr_addr(app_wr_addr),
    .app_wr_data(app_wr_data), .app_wr_bw_n(app_wr_bw_n), .app_rd_cmd(app_rd_cmd),
    .app_rd_addr(app_rd_addr), .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data),
    .busy(busy), .done(done), .error(error), .timeout_err(timeout_err), .err_count(err_count),
    .first_err_addr(first_err_addr), .pass_count(pass_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0, total = 0, fails = 0;

  task automatic chk(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pattern reference: beat b of address a, built bit by bit from the rules.
  function automatic logic [UW-1:0] ref_word(input int mode, input bit inv, input int a);
    logic [UW-1:0] w;
    logic [DW-1:0] v;
    longint s;
    w = '0;
    for (int b = 0; b < BL; b++) begin
      s = longint'(a + b);
      case (mode)
        0: v = DW'(s);
        1: begin
          v = '0;
          for (int i = 0; i < DW; i++) if (i == (a * BL + b) % DW) v[i] = 1'b1;
        end
        2: v = ~DW'(s);
        default: v = (s % 2 == 0) ? '1 : '0;
      endcase
      if (inv) v = ~v;
      w[b*DW +: DW] = v;
    end
    return w;
  endfunction

  typedef struct { int due; int a; } rd_t;
  rd_t q[$];
  logic [UW-1:0] mem [0:N-1];
  int wr_seen = 0, rd_seen = 0, last_wr_cyc = 0, first_rd_cyc = 0, last_val_cyc = 0;
  int done_cnt = 0, tb_mode = 0, lat = 12, corr_a = -1, corr_b = -1, tb_err = 0;
  bit tb_inv = 0, drop_last = 0, corr_all = 0, errchk_en = 0, errchk_pend = 0;

  // Memory model and command monitor, all sampled mid-cycle.
  initial begin
    rd_t e;
    logic [UW-1:0] d;
    app_rd_valid = 1'b0;
    app_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (errchk_pend) chk("err_timing", UW'(err_count), UW'(tb_err));
      errchk_pend = 0;
      if (app_wr_cmd || app_rd_cmd) chk("cmd_excl", UW'(app_wr_cmd & app_rd_cmd), '0);
      if (app_wr_cmd) begin
        if (wr_seen > 0 && wr_seen % N == 0) tb_inv = ~tb_inv;
        chk("wr_addr", UW'(app_wr_addr), UW'(AS + wr_seen % N));
        chk("wr_data", app_wr_data, ref_word(tb_mode, tb_inv, AS + wr_seen % N));
        mem[int'(app_wr_addr) - AS] = app_wr_data;
        wr_seen++;
        last_wr_cyc = cyc;
      end
      if (app_rd_cmd) begin
        chk("rd_addr", UW'(app_rd_addr), UW'(AS + rd_seen % N));
        if (rd_seen == 0) first_rd_cyc = cyc;
        rd_seen++;
        if (!(drop_last && int'(app_rd_addr) == AE)) q.push_back('{cyc + lat, int'(app_rd_addr)});
      end
      app_rd_valid = 1'b0;
      app_rd_data  = '0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        d = mem[e.a - AS];
        if (corr_all || e.a == corr_a || e.a == corr_b) begin
          d[5] = ~d[5];
          if (errchk_en) begin tb_err++; errchk_pend = 1; end
        end
        app_rd_valid = 1'b1;
        app_rd_data  = d;
        last_val_cyc = cyc;
      end
      if (done) done_cnt++;
    end
  end

  task automatic do_start(input int mode);
    @(negedge clk);
    wr_seen = 0; rd_seen = 0; tb_inv = 0; tb_mode = mode; tb_err = 0;
    pattern_mode = 2'(mode);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_wr_cmd", UW'(app_wr_cmd), UW'(1));
    chk("start_wr_addr", UW'(app_wr_addr), UW'(AS));
  endtask

  task automatic wait_done(input int maxc, output int dc);
    int n = 0;
    while (!done && n < maxc) begin @(negedge clk); n++; end
    chk("done_seen", UW'(done), UW'(1));
    dc = cyc;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, UW'(busy), '0);
    chk({tag, "_done"}, UW'(done), '0);
    chk({tag, "_wr_cmd"}, UW'(app_wr_cmd), '0);
    chk({tag, "_rd_cmd"}, UW'(app_rd_cmd), '0);
    chk({tag, "_error"}, UW'(error), '0);
    chk({tag, "_tmo"}, UW'(timeout_err), '0);
    chk({tag, "_errcnt"}, UW'(err_count), '0);
    chk({tag, "_pass"}, UW'(pass_count), '0);
    chk({tag, "_wr_addr"}, UW'(app_wr_addr), UW'(AS));
    chk({tag, "_rd_addr"}, UW'(app_rd_addr), UW'(AS));
    chk({tag, "_first"}, UW'(first_err_addr), UW'(AS));
    chk({tag, "_wr_data"}, app_wr_data, '0);
    chk({tag, "_bw_n"}, UW'(app_wr_bw_n), '0);
  endtask

  initial begin
    int dc, d0, n, k, m;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1; calib = 1'b1;
    @(negedge clk);

    // clean pass, mode 0, 12-cycle latency
    lat = 12;
    do_start(0);
    wait_done(300, dc);
    chk("clean_wr_n", UW'(wr_seen), UW'(N));
    chk("clean_rd_n", UW'(rd_seen), UW'(N));
    chk("clean_rd_follows_wr", UW'(first_rd_cyc), UW'(last_wr_cyc + 1));
    chk("clean_done_lat", UW'(dc - last_val_cyc), UW'(2));
    chk("clean_errcnt", UW'(err_count), '0);
    chk("clean_error", UW'(error), '0);
    chk("clean_pass", UW'(pass_count), UW'(1));
    chk("clean_busy", UW'(busy), '0);
    @(negedge clk);
    chk("clean_done_pulse", UW'(done), '0);

    // corruption at 7 then 11, mode 1
    corr_a = 7; corr_b = 11; errchk_en = 1;
    do_start(1);
    wait_done(300, dc);
    chk("corr_error", UW'(error), UW'(1));
    chk("corr_errcnt", UW'(err_count), UW'(2));
    chk("corr_first", UW'(first_err_addr), UW'(7));
    chk("corr_pass", UW'(pass_count), UW'(1));
    corr_a = -1; corr_b = -1; errchk_en = 0;

    // looping, mode 3
    loop_en = 1'b1;
    do_start(3);
    n = 0;
    while (pass_count < 16'd3 && n < 600) begin @(negedge clk); n++; end
    chk("loop_reach3", UW'(pass_count >= 16'd3), UW'(1));
    loop_en = 1'b0;
    wait_done(300, dc);
    chk("loop_pass", UW'(pass_count), UW'(wr_seen / N));
    chk("loop_pass_min", UW'(pass_count >= 16'd3), UW'(1));
    chk("loop_error", UW'(error), '0);
    chk("loop_errcnt", UW'(err_count), '0);

    // timeout: last read dropped
    drop_last = 1;
    do_start(2);
    wait_done(400, dc);
    chk("tmo_flag", UW'(timeout_err), UW'(1));
    chk("tmo_error", UW'(error), UW'(1));
    chk("tmo_errcnt", UW'(err_count), '0);
    chk("tmo_pass", UW'(pass_count), '0);
    chk("tmo_delay", UW'((dc - last_val_cyc) >= TO && (dc - last_val_cyc) <= TO + 1), UW'(1));
    drop_last = 0;

    // calibration loss mid-write
    do_start(0);
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    calib = 1'b0;
    @(negedge clk);
    chk("cal_wr_cmd", UW'(app_wr_cmd), '0);
    chk("cal_rd_cmd", UW'(app_rd_cmd), '0);
    chk("cal_busy", UW'(busy), '0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("cal_start_ignored", UW'(busy | app_wr_cmd), '0);
    repeat (30) @(negedge clk);
    chk("cal_no_done", UW'(done_cnt), UW'(d0));
    chk("cal_tmo_kept", UW'(timeout_err), '0);
    calib = 1'b1;
    repeat (2) @(negedge clk);
    chk("cal_stays_idle", UW'(busy), '0);

    // randomized: latency, mode and corrupted address
    for (int it = 0; it < 3; it++) begin
      lat = $urandom_range(1, 20);
      m   = $urandom_range(0, 3);
      k   = $urandom_range(AS, AE);
      corr_a = k; errchk_en = 1;
      do_start(m);
      wait_done(400, dc);
      chk("rnd_errcnt", UW'(err_count), UW'(1));
      chk("rnd_first", UW'(first_err_addr), UW'(k));
      chk("rnd_pass", UW'(pass_count), UW'(1));
      corr_a = -1; errchk_en = 0;
      repeat (2) @(negedge clk);
    end

    // reset mid-read; stragglers arrive corrupted and must be ignored
    lat = 12; corr_all = 1;
    do_start(0);
    n = 0;
    while (rd_seen < 3 && n < 100) begin @(negedge clk); n++; end
    chk("rstrd_reached", UW'(rd_seen >= 3), UW'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstrd");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rstrd_errcnt_after", UW'(err_count), '0);
    chk("rstrd_error_after", UW'(error), '0);
    corr_all = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
